// File: rtl/prince_cms_pkg.sv
// Shared parameters, index helpers and reference S-box table for the
// masked PRINCE S-box compression stage.
package prince_cms_pkg;

  localparam int unsigned NBITS      = 4;
  localparam int unsigned IN_SHARES  = 8;
  localparam int unsigned OUT_SHARES = 2;

  typedef logic [NBITS*IN_SHARES-1:0]      in_vec_t;
  typedef logic [NBITS*OUT_SHARES-1:0]     out_vec_t;
  typedef logic [NBITS*(OUT_SHARES-1)-1:0] rnd_vec_t;

  // PRINCE S-box, entry x at nibble x (S(0)=B in the low nibble).
  localparam logic [63:0] SBOX_TABLE = 64'h4D5E_0876_19CA_23FB;

  function automatic int unsigned idx(input int unsigned b, input int unsigned s,
                                      input int unsigned n);
    return b * n + s;
  endfunction

  function automatic int unsigned grp(input int unsigned s,
                                      input int unsigned gsize = IN_SHARES / OUT_SHARES);
    return s / gsize;
  endfunction

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] t;
    t = SBOX_TABLE;
    return t[4*x +: 4];
  endfunction

endpackage

// File: rtl/cms_bit_compress.sv
// One S-box output bit: raw share register, group XOR compression,
// ring refresh with fresh randomness, output share register.
module cms_bit_compress #(
  parameter int unsigned IN_SHARES  = prince_cms_pkg::IN_SHARES,
  parameter int unsigned OUT_SHARES = prince_cms_pkg::OUT_SHARES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s1_load,
  input  logic                  s2_load,
  input  logic [IN_SHARES-1:0]  in_sh,
  input  logic [OUT_SHARES-2:0] rnd,
  output logic [OUT_SHARES-1:0] out_sh
);
  import prince_cms_pkg::*;

  logic [IN_SHARES-1:0]  s1_sh_d, s1_sh_q;
  logic [OUT_SHARES-1:0] s2_sh_d, s2_sh_q;
  logic [OUT_SHARES-1:0] comp, refr;

  always_comb begin
    // S1 takes in_sh untouched; compression sees registered shares only.
    s1_sh_d = s1_load ? in_sh : s1_sh_q;

    comp = '0;
    for (int unsigned s = 0; s < IN_SHARES; s++) begin
      comp[grp(s, IN_SHARES / OUT_SHARES)] ^= s1_sh_q[s];
    end

    refr = comp;
    for (int unsigned j = 0; j < OUT_SHARES - 1; j++) begin
      refr[j]            ^= rnd[j];
      refr[OUT_SHARES-1] ^= rnd[j];
    end

    s2_sh_d = s2_load ? refr : s2_sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sh_q <= '0;
      s2_sh_q <= '0;
    end else begin
      s1_sh_q <= s1_sh_d;
      s2_sh_q <= s2_sh_d;
    end
  end

  assign out_sh = s2_sh_q;

endmodule

// File: rtl/prince_sbox_cms_compress.sv
// Two-stage elastic CMS share compressor: NBITS bit slices sharing one
// valid/ready control pair (S1 raw shares, S2 refreshed shares).
module prince_sbox_cms_compress #(
  parameter int unsigned NBITS      = prince_cms_pkg::NBITS,
  parameter int unsigned IN_SHARES  = prince_cms_pkg::IN_SHARES,
  parameter int unsigned OUT_SHARES = prince_cms_pkg::OUT_SHARES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NBITS*IN_SHARES-1:0]        in_sh,
  input  logic [NBITS*(OUT_SHARES-1)-1:0]   rnd,
  output logic                              rnd_ack,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NBITS*OUT_SHARES-1:0]       out_sh,
  output logic                              busy
);
  import prince_cms_pkg::*;

  logic s1_v_d, s1_v_q;
  logic s2_v_d, s2_v_q;
  logic s1_load, s2_load;

  always_comb begin
    s2_load  = s1_v_q && (!s2_v_q || out_ready);
    in_ready = !s1_v_q || s2_load;
    s1_load  = in_valid && in_ready;

    s1_v_d = s1_v_q;
    if (s1_load)      s1_v_d = 1'b1;
    else if (s2_load) s1_v_d = 1'b0;

    s2_v_d = s2_v_q;
    if (s2_load)        s2_v_d = 1'b1;
    else if (out_ready) s2_v_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end

  assign rnd_ack   = s2_load;
  assign out_valid = s2_v_q;
  assign busy      = s1_v_q | s2_v_q;

  for (genvar b = 0; b < NBITS; b++) begin : g_bit
    cms_bit_compress #(
      .IN_SHARES (IN_SHARES),
      .OUT_SHARES(OUT_SHARES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .s1_load(s1_load),
      .s2_load(s2_load),
      .in_sh  (in_sh[idx(b, 0, IN_SHARES) +: IN_SHARES]),
      .rnd    (rnd[idx(b, 0, OUT_SHARES - 1) +: OUT_SHARES - 1]),
      .out_sh (out_sh[idx(b, 0, OUT_SHARES) +: OUT_SHARES])
    );
  end

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// Randomized bench for prince_sbox_cms_compress against a queue-based
// transaction model of the compression/refresh pipeline.
module tb_prince_sbox_cms_compress;
  import prince_cms_pkg::*;

  localparam int unsigned IW = NBITS * IN_SHARES;
  localparam int unsigned OW = NBITS * OUT_SHARES;
  localparam int unsigned RW = NBITS * (OUT_SHARES - 1);
  localparam int unsigned GS = IN_SHARES / OUT_SHARES;
  localparam logic [3:0] SB [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                     4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_sh = '0;
  logic [RW-1:0] rnd = '0;
  logic          rnd_ack;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_sh;
  logic          busy;

  prince_sbox_cms_compress dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sh(in_sh), .rnd(rnd), .rnd_ack(rnd_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_sh(out_sh), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] sh;
    logic [3:0]    nib;
  } item_t;

  item_t         pend_q[$];
  item_t         out_q[$];
  int unsigned   n_checks = 0, n_errors = 0;
  int unsigned   n_acc = 0, n_ack = 0, n_emit = 0;
  logic [3:0]    cur_nib = '0;
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_sh = '0;
  bit            rnd_zero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] recomb(input logic [OW-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int b = 0; b < NBITS; b++)
      for (int j = 0; j < OUT_SHARES; j++) r[b] ^= v[b*OUT_SHARES+j];
    return r;
  endfunction

  // Random sharing of nibble nib: each bit's shares XOR to that bit.
  task automatic make_set(input logic [3:0] nib, input bit only_sh0);
    logic p;
    cur_nib = nib;
    for (int b = 0; b < NBITS; b++) begin
      p = 1'b0;
      for (int s = 0; s < IN_SHARES; s++) begin
        if (only_sh0)                in_sh[b*IN_SHARES+s] = (s == 0) ? nib[b] : 1'b0;
        else if (s == IN_SHARES - 1) in_sh[b*IN_SHARES+s] = p ^ nib[b];
        else begin
          in_sh[b*IN_SHARES+s] = 1'($urandom_range(0, 1));
          p ^= in_sh[b*IN_SHARES+s];
        end
      end
    end
  endtask

  // One clock: sample at negedge+1, update the model for the coming edge.
  task automatic cycle();
    item_t it;
    #1;
    chk("busy", busy, 32'((pend_q.size() + out_q.size()) > 0));
    chk("out_valid", out_valid, 32'(out_q.size() > 0));
    if (prev_stall) chk("stall_hold", out_sh, prev_sh);
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) chk("emit_unexpected", 1, 0);
      else begin
        it = out_q.pop_front();
        chk("out_sh", out_sh, it.sh);
        chk("recombine", recomb(out_sh), it.nib);
        n_emit++;
      end
    end
    if (rnd_ack) begin
      n_ack++;
      if (pend_q.size() == 0) chk("rnd_ack_spurious", 1, 0);
      else begin
        it = pend_q.pop_front();
        for (int b = 0; b < NBITS; b++)
          for (int j = 0; j < OUT_SHARES - 1; j++) begin
            it.sh[b*OUT_SHARES+j]            ^= rnd[b*(OUT_SHARES-1)+j];
            it.sh[b*OUT_SHARES+OUT_SHARES-1] ^= rnd[b*(OUT_SHARES-1)+j];
          end
        out_q.push_back(it);
      end
    end
    if (in_valid && in_ready) begin
      n_acc++;
      it.sh  = '0;
      it.nib = cur_nib;
      for (int b = 0; b < NBITS; b++)
        for (int s = 0; s < IN_SHARES; s++)
          it.sh[b*OUT_SHARES + s/GS] ^= in_sh[b*IN_SHARES+s];
      pend_q.push_back(it);
    end
    if (pend_q.size() > 1 || out_q.size() > 1) chk("capacity", 1, 0);
    prev_stall = out_valid && !out_ready;
    prev_sh    = out_sh;
    @(negedge clk);
    rnd = rnd_zero ? '0 : RW'($urandom);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (busy || pend_q.size() + out_q.size() > 0); i++) cycle();
    chk("drained", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned e0, a0, k0, sent;
    // Reset values
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sh", out_sh, 0);
    chk("rst_rnd_ack", rnd_ack, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single set S(0) on share 0 only, no randomness: two-cycle latency
    rnd_zero  = 1'b1;
    rnd       = '0;
    out_ready = 1'b1;
    make_set(SB[0], 1'b1);
    in_valid  = 1'b1;
    cycle();
    in_valid  = 1'b0;
    chk("lat_c1", out_valid, 0);
    cycle();
    chk("lat_c2", out_valid, 1);
    chk("single_val", recomb(out_sh), 4'hB);
    drain();
    rnd_zero = 1'b0;

    // Back-to-back 16 sets S(0..F) with random shares and randomness
    e0 = n_emit;
    for (int x = 0; x < 16; x++) begin
      make_set(SB[x], 1'b0);
      in_valid = 1'b1;
      #1 chk("b2b_in_ready", in_ready, 1);
      cycle();
    end
    drain();
    chk("b2b_count", n_emit - e0, 16);

    // Stall: out_ready low for 5 cycles while 3 sets are offered
    a0 = n_acc;
    k0 = n_ack;
    e0 = n_emit;
    out_ready = 1'b0;
    make_set(SB[$urandom_range(0, 15)], 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      sent = n_acc - a0;
      in_valid = sent < 3;
      if (sent < 3 && (n_acc - a0) != 0) make_set(SB[$urandom_range(0, 15)], 1'b0);
    end
    chk("stall_accepted", n_acc - a0, 2);
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (n_acc - a0) < 3; i++) begin
      cycle();
      if ((n_acc - a0) >= 3) in_valid = 1'b0;
      else if ((n_acc - a0) != sent) begin
        sent = n_acc - a0;
        make_set(SB[$urandom_range(0, 15)], 1'b0);
      end
    end
    drain();
    chk("stall_emitted", n_emit - e0, 3);
    chk("stall_rnd_ack", n_ack - k0, 3);

    // out_ready toggling every cycle with random offers
    a0 = n_acc;
    e0 = n_emit;
    for (int i = 0; i < 60; i++) begin
      out_ready = i[0];
      if (!in_valid || in_ready) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        make_set(SB[$urandom_range(0, 15)], 1'b0);
      end
      cycle();
    end
    drain();
    chk("toggle_no_loss", n_emit - e0, n_acc - a0);
    chk("total_no_loss", n_emit, n_acc);

    // Mid-stream reset with both stages holding data
    out_ready = 1'b0;
    in_valid  = 1'b1;
    make_set(SB[5], 1'b0);
    cycle();
    make_set(SB[6], 1'b0);
    cycle();
    cycle();
    #1 chk("pre_rst_busy", busy, 1);
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sh", out_sh, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_rnd_ack", rnd_ack, 0);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
